// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - pipeline memory stage with load/store unit; optional MISALIGN_TRAP_EN
module mem_stage_lsu #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              n_rst,
  input  logic [4:0]        rd_i,
  input  logic              alu_zero_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   pc_4_i,
  input  logic [XLEN-1:0]   pc_imm_i,
  input  logic [2:0]        funct3_i,
  input  logic              memread_en_i,
  input  logic              memwrite_en_i,
  input  logic              branch_i,
  input  logic              jmp_i,
  input  logic              wb_en_i,
  input  logic [1:0]        wb_src_i,
  input  logic [1:0]        wb_pc_src_i,
  output logic [4:0]        rd_o,
  output logic              wb_en_o,
  output logic [XLEN-1:0]   wb_value_o,
  output logic [XLEN-1:0]   next_pc_o,
  output logic              branch_taken_o,
  output logic              stall_o,
  output logic              bus_err_o,
`ifdef MISALIGN_TRAP_EN
  output logic              misaligned_o,
`endif
  output logic              mem_req_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  // A zero-width counter is illegal, so keep at least one bit when the timeout is disabled.
  localparam int CNT_W   = (TO_W < 1) ? 1 : TO_W;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic [XLEN-1:0]  load_q;
  logic [XLEN-1:0]  load_ext;
  logic [XLEN-1:0]  st_wdata;
  logic [3:0]       st_we;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [1:0]       a_lo;
  logic             op;
  logic             timeout_hit;

  assign op   = memread_en_i | memwrite_en_i;
  assign a_lo = alu_result_i[1:0];

  // Upstream stages hold their outputs while stalled, so the ALU/funct3 inputs stay valid for the whole access.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (to_cnt >= CNT_W'(TO_LAST));

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((funct3_i[1:0] == 2'b01) && a_lo[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (a_lo != 2'b00));
`endif

  assign stall_o        = op & (state != DONE);
  assign rd_o           = rd_i;
  assign branch_taken_o = jmp_i | (branch_i & ~alu_zero_i);

`ifdef MISALIGN_TRAP_EN
  assign wb_en_o = wb_en_i & ~stall_o & ~misaligned_o;
`else
  assign wb_en_o = wb_en_i & ~stall_o;
`endif

  // Store lane steering: replicate the datum across lanes and enable only the addressed bytes.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = rs2_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_we    = 4'b0001 << a_lo;
        st_wdata = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << {a_lo[1], 1'b0};
        st_wdata = {2{rs2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction: pick the addressed byte/half and sign- or zero-extend (funct3[2] selects unsigned).
  always_comb begin
    case (a_lo)
      2'b00:   ld_byte = mem_rdata_i[7:0];
      2'b01:   ld_byte = mem_rdata_i[15:8];
      2'b10:   ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half  = a_lo[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_ext = mem_rdata_i;
    case (funct3_i[1:0])
      2'b00:   load_ext = {{(XLEN-8){ld_byte[7] & ~funct3_i[2]}}, ld_byte};
      2'b01:   load_ext = {{(XLEN-16){ld_half[15] & ~funct3_i[2]}}, ld_half};
      default: ;
    endcase
  end

  // Access FSM: bus request, response capture, timeout and the one-cycle DONE release.
  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      load_q      <= '0;
      to_cnt      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 4'b0000;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      bus_err_o   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_o <= 1'b0;
`endif
    end else begin
      bus_err_o <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (op) begin
`ifdef MISALIGN_TRAP_EN
            if (misaligned) begin
              state        <= DONE;
              misaligned_o <= 1'b1;
            end else
`endif
            begin
              state       <= REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= memwrite_en_i ? st_we : 4'b0000;
              mem_addr_o  <= {alu_result_i[ADDR_W-1:2], 2'b00};
              mem_wdata_o <= st_wdata;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i && !memread_en_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 4'b0000;
            to_cnt    <= '0;
          end else if (mem_gnt_i && mem_rvalid_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            load_q    <= load_ext;
            to_cnt    <= '0;
          end else if (timeout_hit) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 4'b0000;
            load_q    <= '0;
            bus_err_o <= 1'b1;
            to_cnt    <= '0;
          end else if (mem_gnt_i) begin
            state     <= WAIT;
            mem_req_o <= 1'b0;
            to_cnt    <= to_cnt + 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state  <= DONE;
            load_q <= load_ext;
            to_cnt <= '0;
          end else if (timeout_hit) begin
            state     <= DONE;
            load_q    <= '0;
            bus_err_o <= 1'b1;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          to_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback value select.
  always_comb begin
    case (wb_src_i)
      2'd0:    wb_value_o = '0;
      2'd1:    wb_value_o = alu_result_i;
      2'd2:    wb_value_o = pc_4_i;
      default: wb_value_o = load_q;
    endcase
  end

  // Next-PC select.
  always_comb begin
    case (wb_pc_src_i)
      2'd0:    next_pc_o = '0;
      2'd1:    next_pc_o = alu_result_i;
      2'd2:    next_pc_o = pc_4_i;
      default: next_pc_o = pc_imm_i;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk_i;
  logic        n_rst;
  logic [4:0]  rd_i;
  logic        alu_zero_i;
  logic [31:0] alu_result_i;
  logic [31:0] rs2_data_i;
  logic [31:0] pc_4_i;
  logic [31:0] pc_imm_i;
  logic [2:0]  funct3_i;
  logic        memread_en_i;
  logic        memwrite_en_i;
  logic        branch_i;
  logic        jmp_i;
  logic        wb_en_i;
  logic [1:0]  wb_src_i;
  logic [1:0]  wb_pc_src_i;
  logic [4:0]  rd_o;
  logic        wb_en_o;
  logic [31:0] wb_value_o;
  logic [31:0] next_pc_o;
  logic        branch_taken_o;
  logic        stall_o;
  logic        bus_err_o;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned_o;
`endif
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu dut (
    .clk_i          (clk_i),
    .n_rst          (n_rst),
    .rd_i           (rd_i),
    .alu_zero_i     (alu_zero_i),
    .alu_result_i   (alu_result_i),
    .rs2_data_i     (rs2_data_i),
    .pc_4_i         (pc_4_i),
    .pc_imm_i       (pc_imm_i),
    .funct3_i       (funct3_i),
    .memread_en_i   (memread_en_i),
    .memwrite_en_i  (memwrite_en_i),
    .branch_i       (branch_i),
    .jmp_i          (jmp_i),
    .wb_en_i        (wb_en_i),
    .wb_src_i       (wb_src_i),
    .wb_pc_src_i    (wb_pc_src_i),
    .rd_o           (rd_o),
    .wb_en_o        (wb_en_o),
    .wb_value_o     (wb_value_o),
    .next_pc_o      (next_pc_o),
    .branch_taken_o (branch_taken_o),
    .stall_o        (stall_o),
    .bus_err_o      (bus_err_o),
`ifdef MISALIGN_TRAP_EN
    .misaligned_o   (misaligned_o),
`endif
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] data, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd);
    memwrite_en_i = 1'b1;
    memread_en_i  = 1'b0;
    funct3_i      = f3;
    alu_result_i  = addr;
    rs2_data_i    = data;
    wb_en_i       = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, {31'd0, stall_o}, 32'd1);
    chk({tag, "_idle_req"}, {31'd0, mem_req_o}, 32'd0);
    step;
    #1;
    chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd1);
    chk({tag, "_we"}, {28'd0, mem_we_o}, {28'd0, exp_we});
    chk({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_wdata"}, mem_wdata_o, exp_wd);
    chk({tag, "_req_stall"}, {31'd0, stall_o}, 32'd1);
    mem_gnt_i = 1'b1;
    step;
    mem_gnt_i = 1'b0;
    #1;
    chk({tag, "_done_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_done_req"}, {31'd0, mem_req_o}, 32'd0);
    chk({tag, "_done_we"}, {28'd0, mem_we_o}, 32'd0);
    step;
    memwrite_en_i = 1'b0;
    #1;
  endtask

  // lat = 0: gnt and rvalid together; lat = n: rvalid n cycles after gnt.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input int lat, input logic [31:0] rdata, input logic [31:0] exp);
    memread_en_i  = 1'b1;
    memwrite_en_i = 1'b0;
    funct3_i      = f3;
    alu_result_i  = addr;
    wb_src_i      = 2'd3;
    wb_en_i       = 1'b1;
    #1;
    chk({tag, "_idle_stall"}, {31'd0, stall_o}, 32'd1);
    chk({tag, "_idle_wben"}, {31'd0, wb_en_o}, 32'd0);
    chk({tag, "_idle_req"}, {31'd0, mem_req_o}, 32'd0);
    step;
    #1;
    chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd1);
    chk({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_we"}, {28'd0, mem_we_o}, 32'd0);
    mem_gnt_i = 1'b1;
    if (lat == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata;
    end
    for (int i = 0; i < lat; i++) begin
      step;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      #1;
      chk({tag, "_wait_stall"}, {31'd0, stall_o}, 32'd1);
      if (i == lat - 1) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
      end
    end
    step;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h5A5A5A5A;
    #1;
    chk({tag, "_done_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_value"}, wb_value_o, exp);
    chk({tag, "_done_wben"}, {31'd0, wb_en_o}, 32'd1);
    step;
    memread_en_i = 1'b0;
    #1;
  endtask

  initial begin
    n_rst         = 1'b0;
    rd_i          = 5'd17;
    alu_zero_i    = 1'b0;
    alu_result_i  = 32'h0000_1000;
    rs2_data_i    = 32'h0;
    pc_4_i        = 32'h0000_2004;
    pc_imm_i      = 32'h0000_3000;
    funct3_i      = 3'b010;
    memread_en_i  = 1'b0;
    memwrite_en_i = 1'b0;
    branch_i      = 1'b0;
    jmp_i         = 1'b0;
    wb_en_i       = 1'b0;
    wb_src_i      = 2'd0;
    wb_pc_src_i   = 2'd0;
    mem_gnt_i     = 1'b0;
    mem_rvalid_i  = 1'b0;
    mem_rdata_i   = 32'h0;
    #3;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {28'd0, mem_we_o}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err_o}, 32'd0);
    chk("rst_stall_noop", {31'd0, stall_o}, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_misaligned", {31'd0, misaligned_o}, 32'd0);
`endif
    memread_en_i = 1'b1;
    #1;
    chk("rst_stall_op", {31'd0, stall_o}, 32'd1);
    memread_en_i = 1'b0;
    step;
    n_rst = 1'b1;
    #1;

    // Muxes and branch resolution with no memory op.
    chk("rd_pass", {27'd0, rd_o}, 32'd17);
    chk("npc_0", next_pc_o, 32'h0);
    wb_pc_src_i = 2'd1; #1; chk("npc_alu", next_pc_o, 32'h0000_1000);
    wb_pc_src_i = 2'd2; #1; chk("npc_pc4", next_pc_o, 32'h0000_2004);
    wb_pc_src_i = 2'd3; #1; chk("npc_imm", next_pc_o, 32'h0000_3000);
    chk("wb_0", wb_value_o, 32'h0);
    wb_src_i = 2'd1; #1; chk("wb_alu", wb_value_o, 32'h0000_1000);
    wb_src_i = 2'd2; #1; chk("wb_pc4", wb_value_o, 32'h0000_2004);
    wb_en_i = 1'b1; #1; chk("wben_noop", {31'd0, wb_en_o}, 32'd1);
    chk("br_none", {31'd0, branch_taken_o}, 32'd0);
    jmp_i = 1'b1; #1; chk("br_jmp", {31'd0, branch_taken_o}, 32'd1);
    jmp_i = 1'b0; branch_i = 1'b1; #1; chk("br_nz", {31'd0, branch_taken_o}, 32'd1);
    alu_zero_i = 1'b1; #1; chk("br_z", {31'd0, branch_taken_o}, 32'd0);
    branch_i = 1'b0; alu_zero_i = 1'b0; wb_en_i = 1'b0;

    // Stores.
    do_store("sw", 32'h0000_0104, 3'b010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_store("sb", 32'h0000_0103, 3'b000, 32'h0000_00A5, 4'b1000, 32'hA5A5A5A5);
    do_store("sh", 32'h0000_0102, 3'b001, 32'h1234_BEEF, 4'b1100, 32'hBEEFBEEF);
    do_store("sb0", 32'h0000_0200, 3'b000, 32'h0000_0011, 4'b0001, 32'h11111111);

    // Loads.
    do_load("lb", 32'h0000_0101, 3'b000, 3, 32'h0000_8000, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_0101, 3'b100, 3, 32'h0000_8000, 32'h0000_0080);
    do_load("lh", 32'h0000_0102, 3'b001, 0, 32'h7FFF_1234, 32'h0000_7FFF);
    do_load("lh_neg", 32'h0000_0100, 3'b001, 1, 32'h1234_F00D, 32'hFFFF_F00D);
    do_load("lhu", 32'h0000_0100, 3'b101, 0, 32'h1234_F00D, 32'h0000_F00D);
    do_load("lw", 32'h0000_0108, 3'b010, 2, 32'h89AB_CDEF, 32'h89AB_CDEF);
`ifndef MISALIGN_TRAP_EN
    do_load("lw_forced", 32'h0000_0102, 3'b010, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
`endif

    // Reset while waiting for the read response.
    memread_en_i = 1'b1;
    funct3_i     = 3'b010;
    alu_result_i = 32'h0000_0300;
    wb_src_i     = 2'd3;
    wb_en_i      = 1'b1;
    step;
    mem_gnt_i = 1'b1;
    step;
    mem_gnt_i = 1'b0;
    #1;
    chk("wait_stall", {31'd0, stall_o}, 32'd1);
    n_rst = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst_loadq", wb_value_o, 32'h0);
    memread_en_i = 1'b0;
    step;
    n_rst        = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    #1;
    chk("postrst_stall", {31'd0, stall_o}, 32'd0);
    step;
    mem_rvalid_i = 1'b0;
    #1;
    chk("postrst_value", wb_value_o, 32'h0);
    chk("postrst_req", {31'd0, mem_req_o}, 32'd0);
    do_load("post_rst", 32'h0000_0304, 3'b010, 0, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

    // Timeout: gnt never arrives.
    memread_en_i = 1'b1;
    funct3_i     = 3'b010;
    alu_result_i = 32'h0000_0200;
    wb_src_i     = 2'd3;
    #1;
    chk("to_idle_stall", {31'd0, stall_o}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      step;
      #1;
      chk("to_req", {31'd0, mem_req_o}, 32'd1);
      chk("to_no_err", {31'd0, bus_err_o}, 32'd0);
    end
    step;
    #1;
    chk("to_buserr", {31'd0, bus_err_o}, 32'd1);
    chk("to_value", wb_value_o, 32'h0);
    chk("to_stall", {31'd0, stall_o}, 32'd0);
    chk("to_req_drop", {31'd0, mem_req_o}, 32'd0);
    step;
    memread_en_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    #1;
    chk("to_err_pulse", {31'd0, bus_err_o}, 32'd0);
    step;
    mem_rvalid_i = 1'b0;
    #1;
    chk("to_late_rvalid", wb_value_o, 32'h0);

`ifdef MISALIGN_TRAP_EN
    memread_en_i = 1'b1;
    funct3_i     = 3'b010;
    alu_result_i = 32'h0000_0102;
    wb_en_i      = 1'b1;
    #1;
    chk("mis_idle_req", {31'd0, mem_req_o}, 32'd0);
    step;
    #1;
    chk("mis_flag", {31'd0, misaligned_o}, 32'd1);
    chk("mis_req", {31'd0, mem_req_o}, 32'd0);
    chk("mis_we", {28'd0, mem_we_o}, 32'd0);
    chk("mis_wben", {31'd0, wb_en_o}, 32'd0);
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    step;
    memread_en_i = 1'b0;
    #1;
    chk("mis_pulse", {31'd0, misaligned_o}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised pipeline memory stage with a full load/store unit. It handles LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane steering and sign/zero extension. The data-memory port is a req/gnt/rvalid handshake with variable latency, not a fixed one-cycle delay. Sits between execute and writeback; it resolves branch/jump next-PC, selects the writeback value, and stalls the pipeline until the memory access completes or times out.

Parameters:
XLEN, 32, datapath width; only 32 is supported; byte lanes = XLEN/8 = 4
ADDR_W, 32, width of the memory address bus
TIMEOUT_CYCLES, 16, max cycles in REQ+WAIT before a bus error; 0 disables the timeout
TO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived)

Ports:
clk_i  in  1  clock
n_rst  in  1  asynchronous active-low reset
rd_i  in  5  destination register
alu_zero_i  in  1  ALU zero flag
alu_result_i  in  XLEN  ALU result / effective address
rs2_data_i  in  XLEN  store data
pc_4_i  in  XLEN  PC+4
pc_imm_i  in  XLEN  PC+imm
funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
memread_en_i  in  1  load
memwrite_en_i  in  1  store
branch_i  in  1  conditional branch
jmp_i  in  1  unconditional jump
wb_en_i  in  1  writeback enable
wb_src_i  in  2  0 zero, 1 ALU, 2 PC+4, 3 load data
wb_pc_src_i  in  2  0 zero, 1 ALU, 2 PC+4, 3 PC+imm
rd_o  out  5  = rd_i
wb_en_o  out  1  writeback enable (gated)
wb_value_o  out  XLEN  writeback value
next_pc_o  out  XLEN  next PC
branch_taken_o  out  1  jmp_i | (branch_i & ~alu_zero_i)
stall_o  out  1  hold upstream stages
bus_err_o  out  1  one-cycle pulse on timeout
mem_req_o  out  1  request valid
mem_we_o  out  4  byte write enables (0 for loads)
mem_addr_o  out  ADDR_W  word-aligned address (addr[1:0]=0)
mem_wdata_o  out  XLEN  lane-steered store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  XLEN  read data

Behaviour:
- op = memread_en_i | memwrite_en_i. FSM states: IDLE, REQ, WAIT, DONE.
- Reset: state IDLE; load_q = 0; timeout counter = 0; mem_req_o = 0; mem_we_o = 0; bus_err_o = 0.
- stall_o = op & (state != DONE), combinational; it is 1 during reset if op is high.
- wb_en_o = wb_en_i & ~stall_o.
- IDLE: if op, go to REQ next cycle. No bus activity in IDLE; rvalid/gnt are ignored.
- REQ: mem_req_o = 1; address, data and we are held stable until gnt.
  - Store with gnt -> DONE.
  - Load with gnt and rvalid in the same cycle -> capture, go to DONE.
  - Load with gnt only -> WAIT.
- WAIT: on rvalid, capture the extended data into load_q and go to DONE.
- DONE: stall released for exactly one cycle; the pipeline advances; next state IDLE. A back-to-back op is re-detected in IDLE, giving a minimum of 3 cycles per access.
- Timeout: the counter increments in REQ/WAIT and clears elsewhere. When it reaches TIMEOUT_CYCLES: go to DONE, set load_q = 0, drop mem_req_o, pulse bus_err_o in the DONE cycle. A late rvalid after this is ignored.
- Store lanes:
  - SB: we = 4'b0001 << a[1:0]; data = {4{rs2[7:0]}}.
  - SH: we = 4'b0011 << (2*a[1]); data = {2{rs2[15:0]}}.
  - SW: we = 4'b1111; data = rs2.
- Load extraction: byte at a[1:0] or half at a[1], then sign-extend (B/H) or zero-extend (BU/HU); W uses the full word.
- Misaligned access without the optional feature: low address bits are dropped for half/word, forcing alignment.
- Reset mid-operation: return to IDLE immediately; any in-flight response is discarded.
- wb_value_o / next_pc_o: 4:1 muxes per sel encodings above; wb sel 3 = load_q.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output misaligned_o (1 bit, reset 0).
  - Misaligned = LH/LHU/SH with a[0] = 1, or LW/SW with a[1:0] != 0.
  - A misaligned op goes IDLE -> DONE with no bus request; mem_we_o stays 0.
  - misaligned_o pulses in the DONE cycle; wb_en_o is forced to 0 in that cycle.
- Undefined: no port; misaligned accesses are force-aligned as above.

Test Plan:
- SW addr 0x104, rs2=0xDEADBEEF, gnt in REQ first cycle -> mem_we_o=4'hF, mem_addr_o=0x104, stall_o high 2 cycles then low 1 cycle.
- SB addr 0x103, rs2=0x000000A5 -> mem_we_o=4'b1000, mem_wdata_o=0xA5A5A5A5.
- LB addr 0x101, rdata=0x0000_80_00 with rvalid 3 cycles after gnt -> wb_value_o=0xFFFFFF80 in DONE with wb_src=3; LBU -> 0x00000080.
- LH addr 0x102, gnt+rvalid same cycle, rdata=0x7FFF1234 -> wb_value_o=0x00007FFF, total 3 cycles.
- Load, gnt never asserted, TIMEOUT_CYCLES=16 -> bus_err_o pulse after 16 REQ cycles, wb_value_o=0, stall released; a late rvalid is ignored.
- Assert n_rst low while in WAIT -> state IDLE, mem_req_o=0; a subsequent rvalid causes no writeback; with MISALIGN_TRAP_EN, LW at 0x102 -> misaligned_o=1, no mem_req_o, wb_en_o=0.
